alu_req_sched: RTL
==================

# alu_req_sched

Two-requester scheduler that shares one ALU instance between independent clients. It accepts complete operations from either requester over valid/ready handshakes and arbitrates between them. It drives the ALU's operand/command inputs with `inp_valid = 2'b11` for exactly one cycle, waits the command-dependent ALU latency, then returns the result and flags to the issuing requester. It sits between the client blocks and the ALU, and it is the only driver of the ALU's input pins.

## Interface
Parameters:
- `W`, 8, ALU operand width; the ALU result is `W+1` bits.
- `LAT`, 1, cycles from the ALU input-drive edge to a valid ALU output for all commands except multiply.
- `MUL_LAT`, 2, the same latency for `mode=1`, `cmd=9` or `cmd=10`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester operation valid.
- `req_ready` out 2: per-requester accept; at most one bit is high.
- `req_opa` in 2*W: packed operand A; requester i uses `[i*W +: W]`.
- `req_opb` in 2*W: packed operand B, same packing.
- `req_mode` in 2, `req_cin` in 2: per-requester mode and carry-in.
- `req_cmd` in 8: packed 4-bit commands.
- `alu_ce` out 1: ALU clock enable.
- `alu_opa` out W, `alu_opb` out W, `alu_mode` out 1, `alu_cin` out 1, `alu_cmd` out 4: ALU inputs.
- `alu_inp_valid` out 2: ALU operand-valid.
- `alu_res` in W+1: ALU result.
- `alu_cout`, `alu_oflow`, `alu_g`, `alu_l`, `alu_e`, `alu_err` in 1 each: ALU flags.
- `rsp_valid` out 2: one-hot response valid.
- `rsp_ready` in 2: per-requester response accept.
- `rsp_res` out W+1: shared response result bus.
- `rsp_flags` out 6: `{cout,oflow,g,l,e,err}`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: on handshake `req_valid[i] && req_ready[i]`, latch requester i's fields and its owner index, then go to ISSUE.
  - ISSUE: drive the latched fields with `alu_inp_valid=2'b11` for one cycle. Load the wait counter with `MUL_LAT` if `mode=1 && cmd∈{9,10}`, else `LAT`. Go to WAIT.
  - WAIT: decrement the counter. When it expires, capture `alu_res` and the flags into the response registers and go to RESP.
  - RESP: assert `rsp_valid[owner]` and hold the data stable. On `rsp_ready[owner]`, go to IDLE.
- `req_ready` is combinational: it is high only in IDLE, only for the grant winner, and only when that requester's valid is high.
- Grant: if only one requester is valid, it wins. If both are valid, arbitration follows the Configuration section.
- The scheduler has no back-to-back issue. Each operation occupies `LAT+3` or `MUL_LAT+3` cycles at minimum.
- `alu_err` is passed through unchanged in `rsp_flags[0]`; the scheduler never suppresses or retries an errored operation.
- `alu_inp_valid` is `2'b00` in every state except ISSUE. `alu_ce` is 1 whenever `rst` is low.
- Reset values:
  - FSM is IDLE.
  - All `alu_*` outputs are 0, including `alu_ce=0`.
  - `rsp_valid=0`, `rsp_res=0`, `rsp_flags=0`, `req_ready=0`.
  - Round-robin pointer is 0.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: ISSUE, with ALU inputs registered and valid.
- Cycles 2 to 1+L: WAIT, where L is the selected latency.
- Cycle 2+L: `rsp_valid` is high, and stays high until `rsp_ready`.
- If `rsp_ready` is already high when `rsp_valid` rises, the transfer completes that cycle. IDLE follows on the next cycle, and a new handshake is possible there, not earlier.
- `rsp_ready` on a non-owner bit is ignored.
- `rst` asserted in any state: at the next edge the FSM returns to IDLE and all outputs take their reset values. Any in-flight operation and any pending response are discarded; no response is ever produced for them.
- Requester fields are sampled only on the handshake edge. Changes after that edge do not affect the issued operation.

## Configuration
- `ALU_REQ_SCHED_RR_EN` defined: round-robin arbitration.
  - The pointer names the requester favoured on a tie.
  - After every handshake the pointer is set to the other requester.
- `ALU_REQ_SCHED_RR_EN` undefined: fixed priority, requester 0 always wins ties. The pointer register is not built.

## Structure
- Shared package `alu_sched_pkg` holds:
  - the `W` default;
  - the 4-bit command constants, including `CMD_MUL_INC=9` and `CMD_MUL_SHL=10`;
  - the FSM state enum;
  - flag index constants for `rsp_flags`.
- One sub-module, `alu_rr_grant`: a 2-way grant. Its inputs are `valid[1:0]` and the pointer; its output is a one-hot grant. It is combinational, with the pointer register kept in the parent.

## Test plan
- Single request from requester 0: `opa=8'h05`, `opb=8'h03`, `mode=1`, `cmd=0`, `LAT=1`. Expect `alu_inp_valid=2'b11` in cycle 1 only, then `rsp_valid=2'b01` in cycle 3 with `rsp_res=9'h008`.
- Multiply: `mode=1`, `cmd=9`, `opa=3`, `opb=4`, `MUL_LAT=2`. Expect `rsp_valid` in cycle 4 with `rsp_res=20`, i.e. `(3+1)*(4+1)`.
- Both requesters valid continuously, RR build:
  - grants alternate 0, 1, 0, 1 across four operations;
  - the fixed-priority build grants 0 every time.
- Hold `rsp_ready=0` for 10 cycles in RESP. Expect `rsp_valid` and `rsp_res` stable throughout, `req_ready=0` throughout, and no new ALU issue.
- Rotate with `opb=8'h10`, `cmd=12`, `mode=0`. Expect `rsp_flags[0]=1`, passed through from `alu_err`.
- Assert `rst` for one cycle during WAIT. Expect no `rsp_valid` for that operation, all outputs at their reset values, and a fresh request accepted normally after release.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants and types for the two-requester ALU scheduler.
// Holds the default operand width, ALU command codes, FSM state encoding
// and the bit positions of the response flag vector.
package alu_sched_pkg;

  localparam int W_DEF = 8;

  // ALU command codes used by the scheduler (4-bit cmd field)
  localparam logic [3:0] CMD_ADD     = 4'd0;
  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;
  localparam logic [3:0] CMD_ROL     = 4'd12;
  localparam logic [3:0] CMD_ROR     = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Bit positions inside rsp_flags = {cout, oflow, g, l, e, err}
  localparam int FLAG_ERR   = 0;
  localparam int FLAG_E     = 1;
  localparam int FLAG_L     = 2;
  localparam int FLAG_G     = 3;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_COUT  = 5;

  // Multiplies are the only commands with the longer ALU latency
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// alu_rr_grant: combinational 2-way grant. A lone valid requester always
// wins; on a tie the requester named by ptr wins. Output is one-hot or zero.
module alu_rr_grant (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pick the winner from the valid bits, breaking ties with ptr
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched: shares one ALU between two requesters. Accepts one operation
// at a time, issues it to the ALU for a single cycle, waits the command's
// latency, then presents result and flags to the issuing requester.
// Build option: define ALU_REQ_SCHED_RR_EN for round-robin tie breaking;
// otherwise requester 0 wins every tie and no pointer register exists.
module alu_req_sched
  import alu_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_opa,
  input  logic [2*W-1:0] req_opb,
  input  logic [1:0]     req_mode,
  input  logic [1:0]     req_cin,
  input  logic [7:0]     req_cmd,
  output logic           alu_ce,
  output logic [W-1:0]   alu_opa,
  output logic [W-1:0]   alu_opb,
  output logic           alu_mode,
  output logic           alu_cin,
  output logic [3:0]     alu_cmd,
  output logic [1:0]     alu_inp_valid,
  input  logic [W:0]     alu_res,
  input  logic           alu_cout,
  input  logic           alu_oflow,
  input  logic           alu_g,
  input  logic           alu_l,
  input  logic           alu_e,
  input  logic           alu_err,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W:0]     rsp_res,
  output logic [5:0]     rsp_flags
);

  localparam int LAT_MAX = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  sched_state_t   state_reg;
  logic           owner_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   opa_reg;
  logic [W-1:0]   opb_reg;
  logic           mode_reg;
  logic           cin_reg;
  logic [3:0]     cmd_reg;
  logic [1:0]     inp_valid_reg;
  logic [1:0]     rsp_valid_reg;
  logic [W:0]     rsp_res_reg;
  logic [5:0]     rsp_flags_reg;

  logic [1:0]     grant;
  logic           ptr;
  logic           win;
  logic           hs;

  // Unpacked per-requester views of the packed request buses
  logic [W-1:0]   opa_arr [2];
  logic [W-1:0]   opb_arr [2];
  logic [3:0]     cmd_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign opa_arr[gi] = req_opa[gi*W +: W];
      assign opb_arr[gi] = req_opb[gi*W +: W];
      assign cmd_arr[gi] = req_cmd[gi*4 +: 4];
    end
  endgenerate

  alu_rr_grant u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign win       = grant[1];
  assign req_ready = ((state_reg == ST_IDLE) && !rst) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);

`ifdef ALU_REQ_SCHED_RR_EN
  logic ptr_reg;

  // After each accepted request, favour the other requester on the next tie
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (hs) begin
      ptr_reg <= ~win;
    end
  end

  assign ptr = ptr_reg;
`else
  assign ptr = 1'b0;
`endif

  // Accept -> issue one cycle -> wait ALU latency -> hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= 1'b0;
      cnt_reg       <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      mode_reg      <= 1'b0;
      cin_reg       <= 1'b0;
      cmd_reg       <= '0;
      inp_valid_reg <= 2'b00;
      rsp_valid_reg <= 2'b00;
      rsp_res_reg   <= '0;
      rsp_flags_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (hs) begin
            owner_reg     <= win;
            opa_reg       <= opa_arr[win];
            opb_reg       <= opb_arr[win];
            mode_reg      <= req_mode[win];
            cin_reg       <= req_cin[win];
            cmd_reg       <= cmd_arr[win];
            inp_valid_reg <= 2'b11;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          inp_valid_reg <= 2'b00;
          cnt_reg       <= is_mul(mode_reg, cmd_reg) ? CW'(MUL_LAT) : CW'(LAT);
          state_reg     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg <= CW'(1)) begin
            rsp_res_reg                <= alu_res;
            rsp_flags_reg[FLAG_COUT]   <= alu_cout;
            rsp_flags_reg[FLAG_OFLOW]  <= alu_oflow;
            rsp_flags_reg[FLAG_G]      <= alu_g;
            rsp_flags_reg[FLAG_L]      <= alu_l;
            rsp_flags_reg[FLAG_E]      <= alu_e;
            rsp_flags_reg[FLAG_ERR]    <= alu_err;
            rsp_valid_reg              <= owner_reg ? 2'b10 : 2'b01;
            cnt_reg                    <= '0;
            state_reg                  <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid_reg <= 2'b00;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign alu_ce        = ~rst;
  assign alu_opa       = opa_reg;
  assign alu_opb       = opb_reg;
  assign alu_mode      = mode_reg;
  assign alu_cin       = cin_reg;
  assign alu_cmd       = cmd_reg;
  assign alu_inp_valid = inp_valid_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_res       = rsp_res_reg;
  assign rsp_flags     = rsp_flags_reg;

endmodule
